// File: rtl/regfile_32x32_sb_if.sv
// Bus bundle for the 32x32 register file: write port, two read ports and the
// busy scoreboard claim port. clock/reset stay outside as plain ports.
interface regfile_32x32_sb_if;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        ctrl_setBusy;
  logic [4:0]  ctrl_busyReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        busyA;
  logic        busyB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output ctrl_setBusy, ctrl_busyReg,
    input  data_readRegA, data_readRegB, busyA, busyB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  ctrl_setBusy, ctrl_busyReg,
    output data_readRegA, data_readRegB, busyA, busyB
  );
endinterface

// File: rtl/regfile_32x32_sb.sv
// 32x32 architectural register file: r0 hardwired to zero, one write port,
// two combinational read ports with write-through bypass, busy scoreboard.
module regfile_32x32_sb (
  input logic              clock,
  input logic              reset,
  regfile_32x32_sb_if.slave rf
);
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic [WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [DEPTH-1:1] busy_q;
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] set_sel;
  logic [WIDTH-1:0] mux_in [DEPTH];
  logic             hit_a;
  logic             hit_b;

  // One-hot decode with bit 0 never asserted, so r0 can neither load nor go busy.
  function automatic logic [DEPTH-1:0] decode(input logic en, input logic [AW-1:0] addr);
    logic [DEPTH-1:0] sel;
    sel = '0;
    for (int k = 1; k < DEPTH; k++) begin
      sel[k] = en && (addr == AW'(k));
    end
    return sel;
  endfunction

  assign wr_sel  = decode(rf.ctrl_writeEnable, rf.ctrl_writeReg);
  assign set_sel = decode(rf.ctrl_setBusy, rf.ctrl_busyReg);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 1; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (wr_sel[k]) begin
          regs_q[k] <= rf.data_writeReg;
        end
      end
    end
  end

  // Set is applied after clear so a re-claim of the register being written wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~wr_sel[DEPTH-1:1]) | set_sel[DEPTH-1:1];
    end
  end

  assign busy_vec = {busy_q, 1'b0};

  always_comb begin
    mux_in[0] = '0;
    for (int k = 1; k < DEPTH; k++) begin
      mux_in[k] = regs_q[k];
    end
  end

  assign hit_a = rf.ctrl_writeEnable && (rf.ctrl_writeReg == rf.ctrl_readRegA)
                 && (rf.ctrl_readRegA != '0);
  assign hit_b = rf.ctrl_writeEnable && (rf.ctrl_writeReg == rf.ctrl_readRegB)
                 && (rf.ctrl_readRegB != '0);

  assign rf.data_readRegA = hit_a ? rf.data_writeReg : mux_in[rf.ctrl_readRegA];
  assign rf.data_readRegB = hit_b ? rf.data_writeReg : mux_in[rf.ctrl_readRegB];

  // An arriving result releases the stall in the same cycle it is written.
  assign rf.busyA = busy_vec[rf.ctrl_readRegA] & ~hit_a;
  assign rf.busyB = busy_vec[rf.ctrl_readRegB] & ~hit_b;
endmodule

// File: tb/tb_regfile_32x32_sb.sv
// Directed, table-driven bench for regfile_32x32_sb: per-cycle vectors with
// same-cycle expected outputs, plus fill and mid-operation reset sequences.
module tb_regfile_32x32_sb;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  regfile_32x32_sb_if rf_bus ();

  regfile_32x32_sb dut (
    .clock (clock),
    .reset (reset),
    .rf    (rf_bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        set;
    logic [4:0]  ba;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eba;
    logic        ebb;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic set, input logic [4:0] ba,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic eba, input logic ebb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.set = set; v.ba = ba; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic set, input logic [4:0] ba);
    rf_bus.ctrl_writeEnable = we;
    rf_bus.ctrl_writeReg    = wa;
    rf_bus.data_writeReg    = wd;
    rf_bus.ctrl_readRegA    = ra;
    rf_bus.ctrl_readRegB    = rb;
    rf_bus.ctrl_setBusy     = set;
    rf_bus.ctrl_busyReg     = ba;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
      #2;
      check($sformatf("%s r%0d A", tag, i), rf_bus.data_readRegA, 32'h0);
      check($sformatf("%s r%0d B", tag, 31 - i), rf_bus.data_readRegB, 32'h0);
      check($sformatf("%s busyA r%0d", tag, i), {31'h0, rf_bus.busyA}, 32'h0);
      check($sformatf("%s busyB r%0d", tag, 31 - i), {31'h0, rf_bus.busyB}, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    //             we  wa     wd            ra     rb     set ba     expA          expB          bA    bB
    vecs[0]  = mk(0, 5'd0,  32'h0,        5'd5,  5'd31, 0, 5'd0,  32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  0, 5'd0,  32'h0,        32'h0,        0, 0);
    vecs[2]  = mk(1, 5'd31, 32'h00000001, 5'd5,  5'd0,  0, 5'd0,  32'hDEADBEEF, 32'h0,        0, 0);
    vecs[3]  = mk(0, 5'd0,  32'h0,        5'd5,  5'd31, 0, 5'd0,  32'hDEADBEEF, 32'h00000001, 0, 0);
    vecs[4]  = mk(0, 5'd0,  32'h0,        5'd6,  5'd30, 0, 5'd0,  32'h0,        32'h0,        0, 0);
    vecs[5]  = mk(1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  0, 5'd0,  32'h0,        32'h0,        0, 0);
    vecs[6]  = mk(0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 5'd0,  32'h0,        32'h0,        0, 0);
    vecs[7]  = mk(1, 5'd7,  32'h11111111, 5'd8,  5'd1,  0, 5'd0,  32'h0,        32'h0,        0, 0);
    vecs[8]  = mk(1, 5'd8,  32'h80808080, 5'd7,  5'd9,  0, 5'd0,  32'h11111111, 32'h0,        0, 0);
    vecs[9]  = mk(1, 5'd7,  32'h22222222, 5'd7,  5'd8,  0, 5'd0,  32'h22222222, 32'h80808080, 0, 0);
    vecs[10] = mk(0, 5'd0,  32'h0,        5'd7,  5'd7,  0, 5'd0,  32'h22222222, 32'h22222222, 0, 0);
    vecs[11] = mk(0, 5'd0,  32'h0,        5'd12, 5'd12, 1, 5'd12, 32'h0,        32'h0,        0, 0);
    vecs[12] = mk(0, 5'd0,  32'h0,        5'd12, 5'd13, 0, 5'd0,  32'h0,        32'h0,        1, 0);
    vecs[13] = mk(1, 5'd12, 32'h0000ABCD, 5'd12, 5'd12, 0, 5'd0,  32'h0000ABCD, 32'h0000ABCD, 0, 0);
    vecs[14] = mk(0, 5'd0,  32'h0,        5'd12, 5'd12, 0, 5'd0,  32'h0000ABCD, 32'h0000ABCD, 0, 0);
    vecs[15] = mk(1, 5'd3,  32'h33333333, 5'd3,  5'd12, 1, 5'd3,  32'h33333333, 32'h0000ABCD, 0, 0);
    vecs[16] = mk(0, 5'd0,  32'h0,        5'd3,  5'd3,  0, 5'd0,  32'h33333333, 32'h33333333, 1, 1);
    vecs[17] = mk(1, 5'd3,  32'h44444444, 5'd3,  5'd0,  0, 5'd0,  32'h44444444, 32'h0,        0, 0);
    vecs[18] = mk(0, 5'd0,  32'h0,        5'd3,  5'd3,  0, 5'd0,  32'h44444444, 32'h44444444, 0, 0);
    vecs[19] = mk(1, 5'd21, 32'h00000021, 5'd20, 5'd21, 1, 5'd20, 32'h0,        32'h00000021, 0, 0);
    vecs[20] = mk(0, 5'd0,  32'h0,        5'd20, 5'd21, 1, 5'd21, 32'h0,        32'h00000021, 1, 0);
    vecs[21] = mk(0, 5'd0,  32'h0,        5'd20, 5'd21, 0, 5'd0,  32'h0,        32'h00000021, 1, 1);
    vecs[22] = mk(1, 5'd20, 32'h00002020, 5'd20, 5'd21, 0, 5'd0,  32'h00002020, 32'h00000021, 0, 1);
    vecs[23] = mk(0, 5'd0,  32'h0,        5'd20, 5'd21, 0, 5'd0,  32'h00002020, 32'h00000021, 0, 1);
    vecs[24] = mk(1, 5'd0,  32'h12345678, 5'd0,  5'd0,  1, 5'd0,  32'h0,        32'h0,        0, 0);
    vecs[25] = mk(0, 5'd0,  32'h0,        5'd0,  5'd21, 0, 5'd0,  32'h0,        32'h00000021, 0, 1);

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    next_cycle();
    reset = 1'b0;

    check_all_zero("after_reset");

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, vecs[i].set, vecs[i].ba);
      #2;
      check($sformatf("vec%0d dataA", i), rf_bus.data_readRegA, vecs[i].ea);
      check($sformatf("vec%0d dataB", i), rf_bus.data_readRegB, vecs[i].eb);
      check($sformatf("vec%0d busyA", i), {31'h0, rf_bus.busyA}, {31'h0, vecs[i].eba});
      check($sformatf("vec%0d busyB", i), {31'h0, rf_bus.busyB}, {31'h0, vecs[i].ebb});
      next_cycle();
    end

    // Fill every register with its own index; claim r9 on the last fill edge.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, (i == 31), 5'd9);
      next_cycle();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
      #2;
      check($sformatf("fill r%0d A", i), rf_bus.data_readRegA, 32'(i));
      check($sformatf("fill r%0d B", 31 - i), rf_bus.data_readRegB, 32'(31 - i));
      check($sformatf("fill busyA r%0d", i), {31'h0, rf_bus.busyA}, (i == 9) ? 32'h1 : 32'h0);
    end

    // Reset together with a write to r4 and a fresh claim of r9: both must be lost.
    reset = 1'b1;
    drive(1'b1, 5'd4, 32'h00000055, 5'd4, 5'd9, 1'b1, 5'd9);
    next_cycle();
    reset = 1'b0;
    check_all_zero("mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
